// File: rtl/switch_debouncer.sv
// Debounces a raw mechanical switch: two-flop synchronizer, four-state stability FSM,
// registered level output, press/release pulses, a press-toggled LED and a press counter.
module switch_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 12000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_sw,
  output logic       o_sw,
  output logic       o_press,
  output logic       o_release,
  output logic       o_led,
  output logic [7:0] o_press_count
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             syncSw;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sw_q, sw_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             led_q;
  logic [7:0]       pressCount_q;

  assign syncSw = sync_q[1];

  // State register; the LED and press counter update on the same edge that raises o_press.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sync_q       <= 2'b00;
      state_q      <= STABLE_LO;
      cnt_q        <= '0;
      sw_q         <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      led_q        <= 1'b0;
      pressCount_q <= 8'd0;
    end else begin
      sync_q       <= {sync_q[0], i_sw};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sw_q         <= sw_d;
      press_q      <= press_d;
      release_q    <= release_d;
      if (press_d) begin
        led_q        <= ~led_q;
        pressCount_q <= pressCount_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      STABLE_LO: begin
        if (syncSw) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!syncSw)                state_d = STABLE_LO;
        else if (cnt_q == LAST_CNT) state_d = STABLE_HI;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      STABLE_HI: begin
        if (!syncSw) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (syncSw)                 state_d = STABLE_HI;
        else if (cnt_q == LAST_CNT) state_d = STABLE_LO;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are derived from the upcoming state so they change on the transition edge itself.
  always_comb begin
    sw_d      = (state_d == STABLE_HI) || (state_d == WAIT_LO);
    press_d   = (state_q == WAIT_HI) && (state_d == STABLE_HI);
    release_d = (state_q == WAIT_LO) && (state_d == STABLE_LO);
  end

  assign o_sw          = sw_q;
  assign o_press       = press_q;
  assign o_release     = release_q;
  assign o_led         = led_q;
  assign o_press_count = pressCount_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with DEBOUNCE_CYCLES=4; a run-length reference model
// predicts every output after each clock edge.
module tb_switch_debouncer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       sw = 1'b0;
  logic       oSw, oPress, oRelease, oLed;
  logic [7:0] oCount;

  int tests = 0;
  int fails = 0;

  // Reference model state: synchronizer delay line plus a run length of samples disagreeing with the accepted level.
  logic       mS1, mS2, mDeb, mPress, mRelease, mLed;
  logic [7:0] mCount;
  int         mRun;

  switch_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .i_clk(clk),
    .i_reset_n(rstN),
    .i_sw(sw),
    .o_sw(oSw),
    .o_press(oPress),
    .o_release(oRelease),
    .o_led(oLed),
    .o_press_count(oCount)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs, advances the model across the edge, then waits past the edge.
  task automatic applyStimulus(input logic swIn, input logic rstIn);
    sw   = swIn;
    rstN = rstIn;
    @(posedge clk);
    if (!rstIn) begin
      mS1 = 0; mS2 = 0; mDeb = 0; mPress = 0; mRelease = 0; mLed = 0; mCount = 0; mRun = 0;
    end else begin
      mPress = 0;
      mRelease = 0;
      if (mS2 != mDeb) begin
        mRun++;
        if (mRun == D + 1) begin
          mDeb = ~mDeb;
          mRun = 0;
          if (mDeb) begin
            mPress = 1;
            mLed = ~mLed;
            mCount = mCount + 8'd1;
          end else begin
            mRelease = 1;
          end
        end
      end else begin
        mRun = 0;
      end
      mS2 = mS1;
      mS1 = swIn;
    end
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    tests++;
    if ({oSw, oPress, oRelease, oLed, oCount} !== 12'h000) begin
      fails++;
      $display("[TB] FAIL reset_state: got %b expected %b", {oSw, oPress, oRelease, oLed, oCount}, 12'h000);
    end
  endtask

  task automatic test_press();
    for (int e = 1; e <= 9; e++) begin
      applyStimulus(1'b1, 1'b1);
      tests++;
      if ({oSw, oPress, oRelease, oLed, oCount} !== {mDeb, mPress, mRelease, mLed, mCount}) begin
        fails++;
        $display("[TB] FAIL press_model edge %0d: got %b expected %b", e,
                 {oSw, oPress, oRelease, oLed, oCount}, {mDeb, mPress, mRelease, mLed, mCount});
      end
      tests++;
      if (e == 6 && (oSw !== 1'b0 || oPress !== 1'b0)) begin
        fails++;
        $display("[TB] FAIL press_early edge 6: got sw=%b press=%b expected sw=0 press=0", oSw, oPress);
      end else if (e == 7 && (oSw !== 1'b1 || oPress !== 1'b1)) begin
        fails++;
        $display("[TB] FAIL press_edge7: got sw=%b press=%b expected sw=1 press=1", oSw, oPress);
      end else if (e == 8 && (oPress !== 1'b0 || oLed !== 1'b1 || oCount !== 8'd1)) begin
        fails++;
        $display("[TB] FAIL press_after edge 8: got press=%b led=%b count=%0d expected 0 1 1", oPress, oLed, oCount);
      end
    end
  endtask

  task automatic test_release();
    for (int e = 1; e <= 9; e++) begin
      applyStimulus(1'b0, 1'b1);
      tests++;
      if ({oSw, oPress, oRelease, oLed, oCount} !== {mDeb, mPress, mRelease, mLed, mCount}) begin
        fails++;
        $display("[TB] FAIL release_model edge %0d: got %b expected %b", e,
                 {oSw, oPress, oRelease, oLed, oCount}, {mDeb, mPress, mRelease, mLed, mCount});
      end
      tests++;
      if (oRelease !== (e == 7) || oLed !== 1'b1 || oCount !== 8'd1 || oSw !== (e < 7)) begin
        fails++;
        $display("[TB] FAIL release_edge %0d: got rel=%b sw=%b led=%b count=%0d expected rel=%b sw=%b led=1 count=1",
                 e, oRelease, oSw, oLed, oCount, (e == 7), (e < 7));
      end
    end
  endtask

  task automatic test_bounce();
    for (int e = 1; e <= 14; e++) begin
      applyStimulus((e <= 3) ? 1'b1 : 1'b0, 1'b1);
      tests++;
      if (oSw !== 1'b0 || oPress !== 1'b0 || oRelease !== 1'b0 || oCount !== 8'd1 || oLed !== 1'b1) begin
        fails++;
        $display("[TB] FAIL bounce edge %0d: got sw=%b press=%b rel=%b led=%b count=%0d expected 0 0 0 1 1",
                 e, oSw, oPress, oRelease, oLed, oCount);
      end
    end
  endtask

  task automatic test_back_to_back();
    int presses = 0;
    int releases = 0;
    applyStimulus(1'b0, 1'b0);
    for (int p = 0; p < 256; p++) begin
      for (int c = 0; c < 18; c++) begin
        applyStimulus((c < 9) ? 1'b1 : 1'b0, 1'b1);
        if (oPress === 1'b1) presses++;
        if (oRelease === 1'b1) releases++;
        tests++;
        if ({oSw, oPress, oRelease, oLed, oCount} !== {mDeb, mPress, mRelease, mLed, mCount}) begin
          fails++;
          $display("[TB] FAIL wrap_model pair %0d cyc %0d: got %b expected %b", p, c,
                   {oSw, oPress, oRelease, oLed, oCount}, {mDeb, mPress, mRelease, mLed, mCount});
        end
      end
    end
    tests++;
    if (presses != 256 || releases != 256 || oCount !== 8'd0 || oLed !== 1'b0) begin
      fails++;
      $display("[TB] FAIL wrap_totals: got press=%0d rel=%0d count=%0d led=%b expected 256 256 0 0",
               presses, releases, oCount, oLed);
    end
  endtask

  task automatic test_reset_priority();
    applyStimulus(1'b0, 1'b0);
    for (int e = 1; e <= 5; e++) applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    tests++;
    if ({oSw, oPress, oRelease, oLed, oCount} !== 12'h000) begin
      fails++;
      $display("[TB] FAIL reset_mid_wait: got %b expected %b", {oSw, oPress, oRelease, oLed, oCount}, 12'h000);
    end
    for (int e = 1; e <= 6; e++) applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    tests++;
    if ({oSw, oPress, oRelease, oLed, oCount} !== 12'h000) begin
      fails++;
      $display("[TB] FAIL reset_on_accept: got %b expected %b", {oSw, oPress, oRelease, oLed, oCount}, 12'h000);
    end
    for (int e = 1; e <= 8; e++) begin
      applyStimulus(1'b1, 1'b1);
      tests++;
      if (oPress !== (e == 7) || oSw !== (e >= 7) || {oSw, oPress, oRelease, oLed, oCount} !== {mDeb, mPress, mRelease, mLed, mCount}) begin
        fails++;
        $display("[TB] FAIL post_reset_press edge %0d: got %b expected %b", e,
                 {oSw, oPress, oRelease, oLed, oCount}, {mDeb, mPress, mRelease, mLed, mCount});
      end
    end
  endtask

  task automatic test_random();
    logic lvl = 1'b0;
    int   hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        lvl  = $urandom_range(0, 1);
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 14) : $urandom_range(1, 6);
      end
      hold--;
      applyStimulus(lvl, ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
      tests++;
      if ({oSw, oPress, oRelease, oLed, oCount} !== {mDeb, mPress, mRelease, mLed, mCount}) begin
        fails++;
        $display("[TB] FAIL random_model cyc %0d: got %b expected %b", c,
                 {oSw, oPress, oRelease, oLed, oCount}, {mDeb, mPress, mRelease, mLed, mCount});
      end
      tests++;
      if (oPress === 1'b1 && oRelease === 1'b1) begin
        fails++;
        $display("[TB] FAIL pulse_exclusive cyc %0d: got press=1 release=1 expected at most one", c);
      end
    end
  endtask

  initial begin
    mS1 = 0; mS2 = 0; mDeb = 0; mPress = 0; mRelease = 0; mLed = 0; mCount = 0; mRun = 0;
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_back_to_back();
    test_reset_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
